// File: rtl/branch_resolve.sv
// rtl/branch_resolve.sv - condition-code banks plus a one-entry branch resolution stage.
// Optional statistics counters are enabled with BRANCH_RESOLVE_STATS_EN.
module branch_resolve #(
    parameter int ADDR_W = 32,
    parameter int NUM_CC = 2,
    parameter int CNT_W  = 16,
    localparam int SEL_W = $clog2(NUM_CC)
) (
    input  logic              i_Clk,
    input  logic              i_Rst_n,
    input  logic              i_CcWrEn,
    input  logic [SEL_W-1:0]  i_CcWrSel,
    input  logic [3:0]        i_AluConditionCodes,
    input  logic              i_BrValid,
    output logic              o_BrReady,
    input  logic [3:0]        i_BranchCond,
    input  logic [SEL_W-1:0]  i_BrCcSel,
    input  logic [ADDR_W-1:0] i_BrTarget,
    input  logic [ADDR_W-1:0] i_BrFallthru,
    input  logic              i_PredTaken,
    input  logic              i_Flush,
    output logic              o_ResValid,
    input  logic              i_ResReady,
    output logic              o_Taken,
    output logic [ADDR_W-1:0] o_NextPc,
    output logic              o_Mispredict
`ifdef BRANCH_RESOLVE_STATS_EN
    ,
    input  logic              i_StatsClr,
    output logic [CNT_W-1:0]  o_BranchCount,
    output logic [CNT_W-1:0]  o_TakenCount,
    output logic [CNT_W-1:0]  o_MispredCount
`endif
);

    localparam logic ST_EMPTY = 1'b0;
    localparam logic ST_FULL  = 1'b1;

    if (NUM_CC < 2 || CNT_W < 1) begin : g_param_check
        $error("branch_resolve: NUM_CC must be >= 2 and CNT_W >= 1");
    end

    logic [3:0]        r_cc [NUM_CC];
    logic              r_state;
    logic              r_taken;
    logic [ADDR_W-1:0] r_next_pc;
    logic              r_mispredict;

    logic [3:0]        w_bank;
    logic [3:0]        w_flags;
    logic              w_cond;
    logic              w_accept;

    // Flags are {C,Z,N,V} from bit 3 down to bit 0.
    function automatic logic f_eval(input logic [3:0] cond, input logic [3:0] cc);
        logic c, z, n, v;
        c = cc[3];
        z = cc[2];
        n = cc[1];
        v = cc[0];
        case (cond)
            4'd0:    f_eval = 1'b1;
            4'd1:    f_eval = ~c;
            4'd2:    f_eval = ~v;
            4'd3:    f_eval = z;
            4'd4:    f_eval = ~(n ^ v);
            4'd5:    f_eval = ~z & ~(n ^ v);
            4'd6:    f_eval = ~n;
            4'd9:    f_eval = c;
            4'd10:   f_eval = v;
            4'd11:   f_eval = ~z;
            4'd12:   f_eval = n ^ v;
            4'd13:   f_eval = z | (n ^ v);
            4'd14:   f_eval = n;
            default: f_eval = 1'b0;
        endcase
    endfunction

    always_comb begin
        w_bank = 4'b0000;
        for (int k = 0; k < NUM_CC; k++) begin
            if (i_BrCcSel == SEL_W'(k)) begin
                w_bank = r_cc[k];
            end
        end
    end

    // A write landing on the bank being tested is forwarded in the same cycle.
    assign w_flags    = (i_CcWrEn && (i_CcWrSel == i_BrCcSel)) ? i_AluConditionCodes : w_bank;
    assign w_cond     = f_eval(i_BranchCond, w_flags);
    assign o_ResValid = (r_state == ST_FULL);
    assign o_BrReady  = ~o_ResValid | i_ResReady;
    assign w_accept   = i_BrValid & o_BrReady & ~i_Flush;

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            for (int k = 0; k < NUM_CC; k++) begin
                r_cc[k] <= 4'b0000;
            end
        end else begin
            for (int k = 0; k < NUM_CC; k++) begin
                if (i_CcWrEn && (i_CcWrSel == SEL_W'(k))) begin
                    r_cc[k] <= i_AluConditionCodes;
                end
            end
        end
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            r_state      <= ST_EMPTY;
            r_taken      <= 1'b0;
            r_next_pc    <= '0;
            r_mispredict <= 1'b0;
        end else if (i_Flush) begin
            r_state <= ST_EMPTY;
        end else if (w_accept) begin
            r_state      <= ST_FULL;
            r_taken      <= w_cond;
            r_next_pc    <= w_cond ? i_BrTarget : i_BrFallthru;
            r_mispredict <= w_cond ^ i_PredTaken;
        end else if (i_ResReady) begin
            r_state <= ST_EMPTY;
        end
    end

    assign o_Taken      = r_taken;
    assign o_NextPc     = r_next_pc;
    assign o_Mispredict = r_mispredict;

`ifdef BRANCH_RESOLVE_STATS_EN
    logic [CNT_W-1:0] r_branch_cnt;
    logic [CNT_W-1:0] r_taken_cnt;
    logic [CNT_W-1:0] r_mispred_cnt;

    // Counters stick at all-ones rather than wrapping.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n || i_StatsClr) begin
            r_branch_cnt  <= '0;
            r_taken_cnt   <= '0;
            r_mispred_cnt <= '0;
        end else if (w_accept) begin
            if (r_branch_cnt != '1) begin
                r_branch_cnt <= r_branch_cnt + 1'b1;
            end
            if (w_cond && (r_taken_cnt != '1)) begin
                r_taken_cnt <= r_taken_cnt + 1'b1;
            end
            if ((w_cond ^ i_PredTaken) && (r_mispred_cnt != '1)) begin
                r_mispred_cnt <= r_mispred_cnt + 1'b1;
            end
        end
    end

    assign o_BranchCount  = r_branch_cnt;
    assign o_TakenCount   = r_taken_cnt;
    assign o_MispredCount = r_mispred_cnt;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// tb/tb_branch_resolve.sv - directed bench for branch_resolve with a reference model.
module tb_branch_resolve;

    localparam int AW = 32;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n, wen, wsel, bv, bsel, pred, flush, rres, clr;
    logic [3:0]    alu, cond;
    logic [AW-1:0] tgt, fall;
    logic          o_BrReady, o_ResValid, o_Taken, o_Mispredict;
    logic [AW-1:0] o_NextPc;
`ifdef BRANCH_RESOLVE_STATS_EN
    logic [CW-1:0] o_BranchCount, o_TakenCount, o_MispredCount;
`endif

    always #5 clk = ~clk;

    branch_resolve #(.ADDR_W(AW), .NUM_CC(2), .CNT_W(CW)) dut (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_CcWrEn(wen), .i_CcWrSel(wsel),
        .i_AluConditionCodes(alu), .i_BrValid(bv), .o_BrReady(o_BrReady),
        .i_BranchCond(cond), .i_BrCcSel(bsel), .i_BrTarget(tgt), .i_BrFallthru(fall),
        .i_PredTaken(pred), .i_Flush(flush), .o_ResValid(o_ResValid),
        .i_ResReady(rres), .o_Taken(o_Taken), .o_NextPc(o_NextPc),
        .o_Mispredict(o_Mispredict)
`ifdef BRANCH_RESOLVE_STATS_EN
        , .i_StatsClr(clr), .o_BranchCount(o_BranchCount),
        .o_TakenCount(o_TakenCount), .o_MispredCount(o_MispredCount)
`endif
    );

    int n_cmp = 0;
    int n_fail = 0;
    bit checking = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference model: codes 8..14 are the negations of codes 0..6; 7 and 15 never take.
    function automatic bit model_cond(input logic [3:0] code, input logic [3:0] f);
        bit c, z, n, v;
        bit base [7];
        c = f[3]; z = f[2]; n = f[1]; v = f[0];
        base[0] = 1'b1;
        base[1] = !c;
        base[2] = !v;
        base[3] = z;
        base[4] = !(n ^ v);
        base[5] = !z && !(n ^ v);
        base[6] = !n;
        if (code[2:0] == 3'd7) return 1'b0;
        return code[3] ? !base[code[2:0]] : base[code[2:0]];
    endfunction

    logic [3:0]    m_cc [2];
    bit            m_valid, m_taken, m_misp;
    logic [AW-1:0] m_pc;
    int            m_bc, m_tc, m_mc;
    localparam int SAT = (1 << CW) - 1;

    always @(posedge clk) begin : model
        bit         rdy, acc, t;
        logic [3:0] fl;
        if (!rst_n) begin
            m_cc[0] = 4'b0; m_cc[1] = 4'b0;
            m_valid = 0; m_taken = 0; m_misp = 0; m_pc = '0;
            m_bc = 0; m_tc = 0; m_mc = 0;
        end else begin
            rdy = !m_valid || rres;
            acc = bv && rdy && !flush;
            fl  = (wen && wsel == bsel) ? alu : m_cc[bsel];
            t   = model_cond(cond, fl);
            if (wen) m_cc[wsel] = alu;
            if (flush) m_valid = 0;
            else if (acc) begin
                m_valid = 1; m_taken = t; m_pc = t ? tgt : fall; m_misp = t ^ pred;
            end else if (rres) m_valid = 0;
            if (clr) begin
                m_bc = 0; m_tc = 0; m_mc = 0;
            end else if (acc) begin
                if (m_bc < SAT) m_bc++;
                if (t && m_tc < SAT) m_tc++;
                if ((t ^ pred) && m_mc < SAT) m_mc++;
            end
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            chk("res_valid", o_ResValid, m_valid);
            chk("br_ready", o_BrReady, (!m_valid || rres));
            if (m_valid) begin
                chk("taken", o_Taken, m_taken);
                chk("next_pc", o_NextPc, m_pc);
                chk("mispredict", o_Mispredict, m_misp);
            end
`ifdef BRANCH_RESOLVE_STATS_EN
            chk("branch_count", o_BranchCount, m_bc);
            chk("taken_count", o_TakenCount, m_tc);
            chk("mispred_count", o_MispredCount, m_mc);
`endif
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bv = 0; wen = 0; flush = 0; clr = 0;
    endtask

    task automatic br(input logic [3:0] c, input logic s, input logic [AW-1:0] t,
                      input logic [AW-1:0] f, input logic p);
        bv = 1; cond = c; bsel = s; tgt = t; fall = f; pred = p;
    endtask

    task automatic wr(input logic s, input logic [3:0] v);
        wen = 1; wsel = s; alu = v;
    endtask

    initial begin
        rst_n = 0; rres = 0; alu = 0; cond = 0; wsel = 0; bsel = 0;
        tgt = 0; fall = 0; pred = 0;
        idle();
        cyc();
        checking = 1'b1;
        cyc();
        chk("rst_valid", o_ResValid, 0);
        chk("rst_taken", o_Taken, 0);
        chk("rst_pc", o_NextPc, 0);
        chk("rst_misp", o_Mispredict, 0);
        chk("rst_ready", o_BrReady, 1);
        rst_n = 1;

        // BEQ on a Z-flag bank
        rres = 1; wr(0, 4'b0100); cyc();
        idle(); br(3, 0, 'h100, 'h104, 0); cyc(); idle();
        chk("beq_valid", o_ResValid, 1);
        chk("beq_taken", o_Taken, 1);
        chk("beq_pc", o_NextPc, 'h100);
        chk("beq_misp", o_Mispredict, 1);
        cyc();
        chk("beq_drain", o_ResValid, 0);

        // same-cycle write forwarding
        wr(1, 4'b0010); cyc();
        wr(1, 4'b0011); br(12, 1, 'h200, 'h204, 1); cyc(); idle();
        chk("blt_bypass_taken", o_Taken, 0);
        chk("blt_bypass_pc", o_NextPc, 'h204);
        chk("blt_bypass_misp", o_Mispredict, 1);
        wr(1, 4'b0010); cyc();
        wr(1, 4'b0011); br(4, 1, 'h210, 'h214, 0); cyc(); idle();
        chk("bge_bypass_taken", o_Taken, 1);
        chk("bge_bypass_pc", o_NextPc, 'h210);

        // write one bank while branching on the other
        wr(0, 4'b1000); br(11, 1, 'h220, 'h224, 0); cyc(); idle();
        chk("bne_other_bank", o_Taken, 1);
        br(9, 0, 'h230, 'h234, 1); cyc(); idle();
        chk("bcs_taken", o_Taken, 1);
        chk("bcs_misp", o_Mispredict, 0);
        cyc();

        // backpressure then back-to-back
        rres = 0; br(0, 0, 'h300, 'h304, 0); cyc();
        chk("bp_load", o_NextPc, 'h300);
        br(0, 0, 'h310, 'h314, 0);
        for (int i = 0; i < 3; i++) begin
            chk("bp_ready_low", o_BrReady, 0);
            cyc();
            chk("bp_hold_pc", o_NextPc, 'h300);
            chk("bp_hold_valid", o_ResValid, 1);
        end
        rres = 1; cyc();
        chk("b2b_first", o_NextPc, 'h310);
        br(0, 0, 'h320, 'h324, 0); cyc();
        chk("b2b_second", o_NextPc, 'h320);
        chk("b2b_valid", o_ResValid, 1);
        idle(); cyc();
        chk("b2b_drain", o_ResValid, 0);

        // flush while full, with a bank write in the same cycle
        rres = 0; br(0, 0, 'h400, 'h404, 0); cyc();
        chk("fl_full", o_ResValid, 1);
        flush = 1; wr(0, 4'b0100); br(0, 0, 'h410, 'h414, 0); cyc(); idle();
        chk("fl_empty", o_ResValid, 0);
        rres = 1; br(3, 0, 'h420, 'h424, 0); cyc(); idle();
        chk("fl_write_kept", o_Taken, 1);
        chk("fl_write_pc", o_NextPc, 'h420);
        cyc();

        // every condition against every flag value
        for (int f = 0; f < 16; f++) begin
            for (int c = 0; c < 16; c++) begin
                logic [3:0] fv, cv;
                fv = 4'(f); cv = 4'(c);
                wr(0, fv); br(cv, 0, {16'h0A00, 8'(f), 8'(c)}, {16'h0F00, 8'(f), 8'(c)}, cv[0]);
                cyc();
                if (c == 7 || c == 15) begin
                    chk("rsv_taken", o_Taken, 0);
                    chk("rsv_pc", o_NextPc, {16'h0F00, 8'(f), 8'(c)});
                end
                if (c == 0) chk("bra_taken", o_Taken, 1);
            end
        end
        idle(); cyc();

        // reset drops a concurrent branch and bank write
        wr(0, 4'b0100); cyc(); idle();
        rst_n = 0; br(0, 0, 'h500, 'h504, 1); wr(1, 4'b1111); cyc();
        chk("rst2_valid", o_ResValid, 0);
        chk("rst2_pc", o_NextPc, 0);
        chk("rst2_taken", o_Taken, 0);
        rst_n = 1; idle(); br(3, 0, 'h510, 'h514, 0); cyc(); idle();
        chk("rst2_bank_clr", o_Taken, 0);
        chk("rst2_bank_pc", o_NextPc, 'h514);
        cyc();

`ifdef BRANCH_RESOLVE_STATS_EN
        clr = 1; cyc(); clr = 0;
        for (int i = 0; i < 20; i++) begin
            br(0, 0, 'h600, 'h604, 1); cyc();
        end
        idle(); cyc();
        chk("st_taken_sat", o_TakenCount, 15);
        chk("st_branch_sat", o_BranchCount, 15);
        chk("st_misp", o_MispredCount, 0);
        clr = 1; br(0, 0, 'h610, 'h614, 0); cyc(); idle();
        chk("st_clr_branch", o_BranchCount, 0);
        chk("st_clr_taken", o_TakenCount, 0);
        chk("st_clr_misp", o_MispredCount, 0);
        cyc();
`endif

        checking = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_resolve.md
BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning program-counter width in bits.
REQ-002 SHALL have parameter NUM_CC, default 2, meaning number of condition-code banks (>=2); SEL_W = $clog2(NUM_CC).
REQ-003 SHALL have parameter CNT_W, default 16, meaning statistics counter width.
REQ-004 SHALL have port i_Clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 SHALL have port i_Rst_n  input  1  reset; synchronous and active-low.
REQ-006 SHALL have port i_CcWrEn  input  1  write the condition-code bank selected by i_CcWrSel.
REQ-007 SHALL have port i_CcWrSel  input  SEL_W  index of the bank to write.
REQ-008 SHALL have port i_AluConditionCodes  input  4  flags {C,Z,N,V} at bits [3:0].
REQ-009 SHALL have port i_BrValid  input  1  branch request valid.
REQ-010 SHALL have port o_BrReady  output  1  unit accepts a branch request this cycle.
REQ-011 SHALL have port i_BranchCond  input  4  condition code of the branch.
REQ-012 SHALL have port i_BrCcSel  input  SEL_W  index of the bank the branch tests.
REQ-013 SHALL have port i_BrTarget  input  ADDR_W  taken address.
REQ-014 SHALL have port i_BrFallthru  input  ADDR_W  not-taken address.
REQ-015 SHALL have port i_PredTaken  input  1  fetch-stage prediction for this branch.
REQ-016 SHALL have port i_Flush  input  1  pipeline flush.
REQ-017 SHALL have port o_ResValid  output  1  result register holds a resolved branch.
REQ-018 SHALL have port i_ResReady  input  1  consumer accepts the result.
REQ-019 SHALL have port o_Taken  output  1  resolved direction.
REQ-020 SHALL have port o_NextPc  output  ADDR_W  resolved next PC.
REQ-021 SHALL have port o_Mispredict  output  1  resolved direction differs from the prediction.

Function
REQ-022 SHALL hold NUM_CC 4-bit banks; a bank is written with i_AluConditionCodes when i_CcWrEn=1.
REQ-023 SHALL evaluate conditions by code: 0 BRA=1; 1 BCC=~C; 2 BVC=~V; 3 BEQ=Z; 4 BGE=~(N^V); 5 BGT=~Z&~(N^V); 6 BPL=~N; 8 BNV=0; 9 BCS=C; 10 BVS=V; 11 BNE=~Z; 12 BLT=N^V; 13 BLE=Z|(N^V); 14 BMI=N; 7 and 15 (reserved)=0.
REQ-024 SHALL bypass writes: when i_CcWrEn=1 and i_CcWrSel=i_BrCcSel in the accept cycle, evaluation uses i_AluConditionCodes and not the stored bank.
REQ-025 SHALL treat a branch as accepted when i_BrValid & o_BrReady & ~i_Flush.
REQ-026 SHALL implement a result stage with states EMPTY and FULL; o_ResValid=1 exactly in FULL.
REQ-027 SHALL drive o_BrReady = ~o_ResValid | i_ResReady, with no dependence on i_BrValid.
REQ-028 SHALL register an accepted branch in the next cycle: o_Taken=cond; o_NextPc=cond?i_BrTarget:i_BrFallthru; o_Mispredict=cond^i_PredTaken. Latency is 1 cycle.
REQ-029 SHALL move EMPTY->FULL on accept; FULL->EMPTY when i_ResReady=1 with no accept; stay FULL and reload on simultaneous drain and accept (back-to-back, one branch per cycle).
REQ-030 SHALL hold o_Taken, o_NextPc and o_Mispredict stable while FULL and i_ResReady=0.
REQ-031 SHALL go to EMPTY on i_Flush=1 in any state, discarding the held result and any request that cycle; bank writes in that cycle still occur.
REQ-032 SHALL write the bank and accept a branch that reads another bank independently in the same cycle.

Reset
REQ-033 SHALL, while i_Rst_n=0 at a clock edge, clear all banks to 4'b0000, enter EMPTY, and drive o_ResValid=0, o_Taken=0, o_NextPc=0, o_Mispredict=0 and all counters to 0.
REQ-034 SHALL drop a branch whose accept cycle coincides with reset; reset has priority over i_Flush, accept and bank write.

Configuration
REQ-035 SHALL, when BRANCH_RESOLVE_STATS_EN is defined, add input i_StatsClr (1 bit) and outputs o_BranchCount, o_TakenCount and o_MispredCount (each CNT_W bits).
REQ-036 SHALL increment the counters on each accept (all, taken, mispredicted), saturate at all-ones, and clear them synchronously on i_StatsClr; clear wins over increment.
REQ-037 SHALL, without BRANCH_RESOLVE_STATS_EN, omit those ports and counter logic, with all other behaviour identical.

Verification
REQ-038 SHALL cover: write bank0=4'b0100 (Z), then BEQ sel0, target 0x100, fallthru 0x104, pred 0 -> next cycle o_ResValid=1, o_Taken=1, o_NextPc=0x100, o_Mispredict=1.
REQ-039 SHALL cover: same-cycle write bank1=4'b0011 (N,V) with BLT sel1 -> o_Taken=0 (bypass); BGE -> o_Taken=1.
REQ-040 SHALL cover: i_ResReady=0 for 3 cycles with i_BrValid=1 -> o_BrReady=0, result stable; then i_ResReady=1 -> one branch per cycle, no gap.
REQ-041 SHALL cover: i_Flush=1 while FULL and i_BrValid=1 -> o_ResValid=0 next cycle, request dropped.
REQ-042 SHALL cover: codes 7 and 15 -> o_Taken=0, o_NextPc=fallthru; BRA -> o_Taken=1 for every flag value.
REQ-043 SHALL cover, with BRANCH_RESOLVE_STATS_EN and CNT_W=4: 20 taken BRA accepts -> o_TakenCount=15 (saturated); i_StatsClr=1 -> all counters 0.
